// File: rtl/osc_wavegen.sv
// DDS oscillator: phase accumulator plus saw/pulse/triangle/noise shaper.
// Emits one 12-bit sample per FRAME_LEN clocks, with a one-cycle STB on each update.
module osc_wavegen #(
  parameter int unsigned FRAME_LEN = 18,
  parameter int unsigned PHASE_W   = 24
) (
  input  logic               ICLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [1:0]         WAVE,
  input  logic [PHASE_W-1:0] FTW,
  input  logic [11:0]        PW,
  output logic [11:0]        DAT,
  output logic               STB
);

  localparam int unsigned      CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    WAVE_SAW   = 2'b00,
    WAVE_PULSE = 2'b01,
    WAVE_TRI   = 2'b10,
    WAVE_NOISE = 2'b11
  } wave_t;

  logic [CNT_W-1:0]   cnt;
  logic [PHASE_W-1:0] phase;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next;
  logic [11:0]        p;
  logic [11:0]        shape;
  logic               tick;
  wave_t              wave;

  always_comb begin
    tick      = (cnt == CNT_LAST);
    wave      = wave_t'(WAVE);
    p         = phase[PHASE_W-1 -: 12];
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  // Shaper works on the pre-add phase and the pre-advance LFSR value.
  always_comb begin
    shape = 12'h800;
    unique case (wave)
      WAVE_SAW:   shape = p;
      WAVE_PULSE: shape = (p < PW) ? 12'hFFF : 12'h000;
      WAVE_TRI:   shape = p[11] ? (12'hFFF - {p[10:0], 1'b0}) : {p[10:0], 1'b0};
      WAVE_NOISE: shape = lfsr[15:4];
      default:    shape = 12'h800;
    endcase
  end

  always_ff @(posedge ICLK) begin
    if (RST) begin
      cnt   <= '0;
      phase <= '0;
      lfsr  <= LFSR_SEED;
      DAT   <= 12'h800;
      STB   <= 1'b0;
    end else begin
      STB <= 1'b0;
      if (tick) begin
        cnt <= '0;
        STB <= 1'b1;
        if (EN) begin
          DAT   <= shape;
          phase <= phase + FTW;
          if (wave == WAVE_NOISE)
            lfsr <= lfsr_next;
        end else begin
          DAT   <= 12'h800;
          phase <= '0;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_osc_wavegen.sv
// Bench for osc_wavegen: directed test-plan scenarios plus randomized inputs,
// every cycle compared against a frame-level arithmetic reference model.
module tb_osc_wavegen;

  localparam int FRAME   = 18;
  localparam int PHW     = 24;

  logic            ICLK = 1'b0;
  logic            RST  = 1'b1;
  logic            EN   = 1'b0;
  logic [1:0]      WAVE = 2'b00;
  logic [PHW-1:0]  FTW  = '0;
  logic [11:0]     PW   = '0;
  logic [11:0]     DAT;
  logic            STB;

  int tests = 0;
  int fails = 0;

  // Reference state: position in frame, phase as integer, LFSR as integer.
  int          m_pos   = 0;
  longint      m_phase = 0;
  int          m_lfsr  = 'hACE1;
  logic [11:0] m_dat   = 12'h800;
  logic        m_stb   = 1'b0;

  osc_wavegen #(.FRAME_LEN(FRAME), .PHASE_W(PHW)) dut (
    .ICLK(ICLK), .RST(RST), .EN(EN), .WAVE(WAVE), .FTW(FTW), .PW(PW),
    .DAT(DAT), .STB(STB)
  );

  always #5 ICLK = ~ICLK;

  function automatic int ref_shape(int w, int p, int pw, int l);
    case (w)
      0:       return p;
      1:       return (p < pw) ? 4095 : 0;
      2:       return (p < 2048) ? 2 * p : 8191 - 2 * p;
      default: return l / 16;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge: reference model advanced with inputs as seen at the edge.
  task automatic step();
    logic r, e; logic [1:0] w; logic [PHW-1:0] f; logic [11:0] pw;
    r = RST; e = EN; w = WAVE; f = FTW; pw = PW;
    @(posedge ICLK);
    if (r) begin
      m_pos = 0; m_phase = 0; m_lfsr = 'hACE1; m_dat = 12'h800; m_stb = 1'b0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0;
      m_stb = 1'b1;
      if (e) begin
        m_dat   = 12'(ref_shape(int'(w), int'(m_phase / 4096), int'(pw), m_lfsr));
        m_phase = (m_phase + longint'(f)) % (longint'(1) << PHW);
        if (w == 2'b11)
          m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 'hB400 : 0);
      end else begin
        m_dat   = 12'h800;
        m_phase = 0;
      end
    end else begin
      m_pos++;
      m_stb = 1'b0;
    end
    #1;
    chk("model_dat", {20'd0, DAT}, {20'd0, m_dat});
    chk("model_stb", {31'd0, STB}, {31'd0, m_stb});
  endtask

  task automatic wait_stb(output int n, output logic [11:0] d);
    n = 0;
    do begin
      step();
      n++;
    end while (STB !== 1'b1 && n < 64);
    if (STB !== 1'b1) chk("stb_timeout", 32'd0, 32'd1);
    d = DAT;
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b1;
    repeat (cycles) step();
    chk("reset_dat", {20'd0, DAT}, 32'h800);
    chk("reset_stb", {31'd0, STB}, 32'd0);
    RST = 1'b0;
  endtask

  initial begin
    int n;
    logic [11:0] d;
    logic [11:0] tri_exp [17];
    tri_exp = '{12'h000, 12'h200, 12'h400, 12'h600, 12'h800, 12'hA00, 12'hC00, 12'hE00,
                12'hFFF, 12'hDFF, 12'hBFF, 12'h9FF, 12'h7FF, 12'h5FF, 12'h3FF, 12'h1FF,
                12'h000};

    // Reset and first-sample timing, saw ramp.
    do_reset(3);
    EN = 1'b1; WAVE = 2'b00; FTW = 24'h001000;
    for (int i = 0; i < 4; i++) begin
      wait_stb(n, d);
      chk("saw_interval", n, FRAME);
      chk("saw_dat", {20'd0, d}, i);
    end

    // Jump phase to FFF000, then watch the saw wrap.
    FTW = 24'hFFB000;
    wait_stb(n, d);
    chk("jump_dat", {20'd0, d}, 32'h004);
    FTW = 24'h001000;
    wait_stb(n, d);
    chk("wrap_interval", n, FRAME);
    chk("wrap_top", {20'd0, d}, 32'hFFF);
    wait_stb(n, d);
    chk("wrap_interval", n, FRAME);
    chk("wrap_zero", {20'd0, d}, 32'h000);

    // Pulse at 50% duty, then PW=0.
    do_reset(2);
    EN = 1'b1; WAVE = 2'b01; PW = 12'h800; FTW = 24'h800000;
    for (int i = 0; i < 4; i++) begin
      wait_stb(n, d);
      chk("pulse_alt", {20'd0, d}, (i % 2 == 0) ? 32'hFFF : 32'h000);
    end
    PW = 12'h000;
    for (int i = 0; i < 3; i++) begin
      wait_stb(n, d);
      chk("pulse_pw0", {20'd0, d}, 32'h000);
    end
    PW = 12'hFFF; FTW = 24'h0FF000;
    for (int i = 0; i < 4; i++) wait_stb(n, d);

    // Triangle full period.
    do_reset(2);
    EN = 1'b1; WAVE = 2'b10; FTW = 24'h100000;
    for (int i = 0; i < 17; i++) begin
      wait_stb(n, d);
      chk("tri_seq", {20'd0, d}, {20'd0, tri_exp[i]});
    end

    // Noise, pause with EN=0, resume from held LFSR.
    do_reset(2);
    EN = 1'b1; WAVE = 2'b11; FTW = 24'h012345;
    wait_stb(n, d); chk("noise_0", {20'd0, d}, 32'hACE);
    wait_stb(n, d); chk("noise_1", {20'd0, d}, 32'hE27);
    EN = 1'b0;
    wait_stb(n, d); chk("noise_off", {20'd0, d}, 32'h800);
    wait_stb(n, d); chk("noise_off2", {20'd0, d}, 32'h800);
    EN = 1'b1;
    wait_stb(n, d); chk("noise_resume", {20'd0, d}, 32'h713);
    wait_stb(n, d); chk("noise_next", {20'd0, d}, 32'h389);

    // Reset at frame counter 9 while running saw.
    do_reset(2);
    EN = 1'b1; WAVE = 2'b00; FTW = 24'h001000;
    wait_stb(n, d);
    wait_stb(n, d);
    repeat (9) step();
    RST = 1'b1;
    step();
    chk("midrst_dat", {20'd0, DAT}, 32'h800);
    chk("midrst_stb", {31'd0, STB}, 32'd0);
    RST = 1'b0;
    wait_stb(n, d);
    chk("midrst_interval", n, FRAME);
    chk("midrst_dat0", {20'd0, d}, 32'h000);
    wait_stb(n, d);
    chk("midrst_dat1", {20'd0, d}, 32'h001);

    // Randomized inputs changing every cycle; only tick-edge values may matter.
    for (int i = 0; i < FRAME * 60; i++) begin
      EN   = ($urandom_range(0, 3) != 0);
      WAVE = 2'($urandom_range(0, 3));
      FTW  = 24'($urandom);
      PW   = 12'($urandom);
      RST  = ($urandom_range(0, 299) == 0);
      step();
    end
    RST = 1'b0;
    for (int i = 0; i < FRAME * 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        WAVE = 2'($urandom_range(0, 3));
        FTW  = 24'($urandom_range(0, 24'h3FFFFF));
        PW   = 12'($urandom);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
